// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, field widths and limits for the timer core
// Purpose: state encoding, field width and per-field maximum values.
// Contents: timer_state_t, FW, SEC_MAX, MIN_MAX, field_max(idx, hr_max).
package timer_pkg;

    typedef enum logic [2:0] {
        ST_PAUSED  = 3'd0,
        ST_RUNNING = 3'd1,
        ST_EDIT_HH = 3'd2,
        ST_EDIT_MM = 3'd3,
        ST_EDIT_SS = 3'd4,
        ST_EXPIRED = 3'd5
    } timer_state_t;

    localparam int FW      = 6;
    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;

    // Field 0 is seconds, field 1 minutes, field 2 hours.
    function automatic int field_max(input int idx, input int hr_max);
        if (idx == 0) begin
            return SEC_MAX;
        end else if (idx == 1) begin
            return MIN_MAX;
        end
        return hr_max;
    endfunction

endpackage

// File: rtl/timer_core_p_field_ctr.sv
// rtl/timer_core_p_field_ctr.sv - one FW-bit mod-(MAX+1) up/down time field
// Purpose: single time field with count, edit-wrap and parallel load.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (value -> 0)
//   en_i, up_i       count step and its direction (carry chain driven)
//   inc_i, dec_i     edit steps; both together cancel
//   load_i, load_val_i  parallel load (auto reload)
//   value_o          current field value
//   carry_o          field sits at its wrap point for direction up_i
module field_ctr
    import timer_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          up_i,
    input  logic          inc_i,
    input  logic          dec_i,
    input  logic          load_i,
    input  logic [FW-1:0] load_val_i,
    output logic [FW-1:0] value_o,
    output logic          carry_o
);

    localparam logic [FW-1:0] MAX_V = FW'(MAX);

    logic [FW-1:0] value_q, value_d;
    logic          at_max, at_zero, step_up, step_dn;

    assign at_max  = (value_q == MAX_V);
    assign at_zero = (value_q == '0);

    // Counting and editing never coincide: the core enables them in disjoint states.
    assign step_up = (en_i & up_i)  | (inc_i & ~dec_i);
    assign step_dn = (en_i & ~up_i) | (dec_i & ~inc_i);

    // Not gated by en_i so the core can test for all-fields-at-limit before stepping.
    assign carry_o = up_i ? at_max : at_zero;

    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = load_val_i;
        end else if (step_up) begin
            value_d = at_max ? '0 : value_q + FW'(1);
        end else if (step_dn) begin
            value_d = at_zero ? MAX_V : value_q - FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/timer_core_p.sv
// rtl/timer_core_p.sv - parametrised MM:SS / HH:MM:SS countdown/countup timer core
// Purpose: run/pause/edit/expire control around FIELDS chained time fields.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (down-count expiry reloads preset).
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   tick       count enable pulse from prescaler
//   dir        0 = count down, 1 = count up
//   pause_p    toggle run/pause, clears alarm
//   mode_p     step through edit fields
//   inc_p      +1 to edited field
//   dec_p      -1 to edited field
//   cnt_o      packed fields [5:0]=SS [11:6]=MM [17:12]=HH
//   blink_o    per-digit blink, bit0 = SS ones
//   edit_o     high in edit states
//   alarm_o    high in EXPIRED
//   done_o     one-cycle pulse on expiry (or reload)
module timer_core_p
    import timer_pkg::*;
#(
    parameter int FIELDS = 2,
    parameter int HR_MAX = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 dir,
    input  logic                 pause_p,
    input  logic                 mode_p,
    input  logic                 inc_p,
    input  logic                 dec_p,
    output logic [6*FIELDS-1:0]  cnt_o,
    output logic [2*FIELDS-1:0]  blink_o,
    output logic                 edit_o,
    output logic                 alarm_o,
    output logic                 done_o
);

    localparam int CW = FW * FIELDS;

    timer_state_t        state_q, state_d;
    logic [CW-1:0]       cnt;
    logic [CW-1:0]       preset_q, preset_d;
    logic [FIELDS-1:0]   carry, f_en, edit_sel;
    logic                all_lim, count_en, load, reload_ok;
    logic                done_q, done_d;
    logic                alarm_q, alarm_d;
    logic                edit_q, edit_d;
    logic [2*FIELDS-1:0] blink_q, blink_d;

    // Every field at its wrap point means the next tick would expire the timer.
    assign all_lim = &carry;

`ifdef TIMER_AUTO_RELOAD_EN
    assign reload_ok = ~dir & (preset_q != '0);
`else
    assign reload_ok = 1'b0;
`endif

    // Next-state logic; priority mode_p > pause_p > tick.
    always_comb begin
        state_d  = state_q;
        preset_d = preset_q;
        done_d   = 1'b0;
        count_en = 1'b0;
        load     = 1'b0;
        if (mode_p) begin
            case (state_q)
                ST_EDIT_HH: state_d = ST_EDIT_MM;
                ST_EDIT_MM: state_d = ST_EDIT_SS;
                ST_EDIT_SS: begin
                    state_d  = ST_PAUSED;
                    preset_d = cnt;
                end
                default: begin
                    if (FIELDS == 3) begin
                        state_d = ST_EDIT_HH;
                    end else begin
                        state_d = ST_EDIT_MM;
                    end
                end
            endcase
        end else if (pause_p) begin
            case (state_q)
                ST_PAUSED:  state_d = ST_RUNNING;
                ST_RUNNING: state_d = ST_PAUSED;
                ST_EXPIRED: state_d = ST_PAUSED;
                default:    state_d = state_q;
            endcase
        end else if (tick && state_q == ST_RUNNING) begin
            if (!all_lim) begin
                count_en = 1'b1;
            end else if (reload_ok) begin
                load   = 1'b1;
                done_d = 1'b1;
            end else begin
                state_d = ST_EXPIRED;
                done_d  = 1'b1;
            end
        end
    end

    // Ripple enable: a field steps only when every lower field wraps.
    always_comb begin
        logic lower;
        f_en  = '0;
        lower = count_en;
        for (int i = 0; i < FIELDS; i++) begin
            f_en[i] = lower;
            lower   = lower & carry[i];
        end
    end

    // Edit strobes reach only the field being edited; mode_p wins over edits.
    always_comb begin
        edit_sel = '0;
        if (!mode_p) begin
            case (state_q)
                ST_EDIT_SS: edit_sel[0] = 1'b1;
                ST_EDIT_MM: edit_sel[1] = 1'b1;
                ST_EDIT_HH: edit_sel[FIELDS-1] = (FIELDS == 3);
                default:    edit_sel = '0;
            endcase
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        blink_d = '0;
        alarm_d = (state_d == ST_EXPIRED);
        edit_d  = (state_d == ST_EDIT_HH) || (state_d == ST_EDIT_MM) ||
                  (state_d == ST_EDIT_SS);
        case (state_d)
            ST_EXPIRED: blink_d = '1;
            ST_EDIT_SS: blink_d[1:0] = 2'b11;
            ST_EDIT_MM: blink_d[3:2] = 2'b11;
            ST_EDIT_HH: blink_d[2*FIELDS-1 -: 2] = 2'b11;
            default:    blink_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_PAUSED;
            preset_q <= '0;
            done_q   <= 1'b0;
            alarm_q  <= 1'b0;
            edit_q   <= 1'b0;
            blink_q  <= '0;
        end else begin
            state_q  <= state_d;
            preset_q <= preset_d;
            done_q   <= done_d;
            alarm_q  <= alarm_d;
            edit_q   <= edit_d;
            blink_q  <= blink_d;
        end
    end

    for (genvar i = 0; i < FIELDS; i++) begin : g_field
        field_ctr #(
            .MAX(field_max(i, HR_MAX))
        ) u_field (
            .clk       (clk),
            .rst       (rst),
            .en_i      (f_en[i]),
            .up_i      (dir),
            .inc_i     (inc_p & edit_sel[i]),
            .dec_i     (dec_p & edit_sel[i]),
            .load_i    (load),
            .load_val_i(preset_q[i*FW +: FW]),
            .value_o   (cnt[i*FW +: FW]),
            .carry_o   (carry[i])
        );
    end

    assign cnt_o   = cnt;
    assign blink_o = blink_q;
    assign edit_o  = edit_q;
    assign alarm_o = alarm_q;
    assign done_o  = done_q;

endmodule

// File: tb/tb_timer_core_p.sv
// tb/tb_timer_core_p.sv - scoreboard bench for timer_core_p (FIELDS=2 and FIELDS=3)
module tb_timer_core_p;

    logic clk = 1'b0;
    logic rst;
    logic tick, dir, pause_p, mode_p, inc_p, dec_p;
    logic sel;

    logic [11:0] cnt2;
    logic [3:0]  blink2;
    logic        edit2, alarm2, done2;
    logic [17:0] cnt3;
    logic [5:0]  blink3;
    logic        edit3, alarm3, done3;

    always #5 clk = ~clk;

    timer_core_p #(.FIELDS(2), .HR_MAX(23)) u_dut2 (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick & ~sel),
        .dir    (dir),
        .pause_p(pause_p & ~sel),
        .mode_p (mode_p & ~sel),
        .inc_p  (inc_p & ~sel),
        .dec_p  (dec_p & ~sel),
        .cnt_o  (cnt2),
        .blink_o(blink2),
        .edit_o (edit2),
        .alarm_o(alarm2),
        .done_o (done2)
    );

    timer_core_p #(.FIELDS(3), .HR_MAX(23)) u_dut3 (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick & sel),
        .dir    (dir),
        .pause_p(pause_p & sel),
        .mode_p (mode_p & sel),
        .inc_p  (inc_p & sel),
        .dec_p  (dec_p & sel),
        .cnt_o  (cnt3),
        .blink_o(blink3),
        .edit_o (edit3),
        .alarm_o(alarm3),
        .done_o (done3)
    );

    typedef struct {
        logic [17:0] cnt;
        logic [5:0]  blink;
        logic        edit;
        logic        alarm;
        logic        done;
    } exp_t;

    exp_t  sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    string phase = "init";

    function automatic logic [17:0] t(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s.%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input exp_t x);
        check("cnt",   sel ? cnt3   : {6'd0, cnt2},   x.cnt);
        check("blink", sel ? blink3 : {2'd0, blink2}, x.blink);
        check("edit",  sel ? edit3  : edit2,          x.edit);
        check("alarm", sel ? alarm3 : alarm2,         x.alarm);
        check("done",  sel ? done3  : done2,          x.done);
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, then compare after the edge.
    task automatic cyc(input logic p, input logic m, input logic i, input logic d, input logic tk,
                       input logic [17:0] c, input logic [5:0] b,
                       input logic e, input logic a, input logic dn);
        exp_t x;
        pause_p = p; mode_p = m; inc_p = i; dec_p = d; tick = tk;
        x.cnt = c; x.blink = b; x.edit = e; x.alarm = a; x.done = dn;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        pause_p = 0; mode_p = 0; inc_p = 0; dec_p = 0; tick = 0;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            x = sb_q.pop_front();
            check_outputs(x);
        end
    endtask

    // Assert reset between edges and confirm outputs clear before any clock edge.
    task automatic do_reset();
        exp_t z;
        z.cnt = '0; z.blink = '0; z.edit = 0; z.alarm = 0; z.done = 0;
        #2;
        rst = 1;
        #1;
        check_outputs(z);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, limit 2000000 expected finish");
        $fatal(1);
    end

    initial begin
        exp_t z;
        rst = 1; sel = 0; dir = 0;
        tick = 0; pause_p = 0; mode_p = 0; inc_p = 0; dec_p = 0;
        z.cnt = '0; z.blink = '0; z.edit = 0; z.alarm = 0; z.done = 0;
        #2;
        phase = "reset";
        check_outputs(z);
        #10;
        rst = 0;
        @(posedge clk);
        #1;

        // ---------------- FIELDS=2, down-count to expiry ----------------
        phase = "idle";
        cyc(0,0,0,0,0, t(0,0,0), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,0), 6'b000000, 0,0,0);
        phase = "set_0100";
        cyc(0,1,0,0,0, t(0,0,0), 6'b001100, 1,0,0);
        cyc(0,0,1,0,0, t(0,1,0), 6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,1,0), 6'b000011, 1,0,0);
        cyc(0,1,0,0,0, t(0,1,0), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,1,0), 6'b000000, 0,0,0);
        phase = "down60";
        for (int k = 1; k <= 60; k++) begin
            cyc(0,0,0,0,1, t(0, (60-k)/60, (60-k)%60), 6'b000000, 0,0,0);
        end
        phase = "expire";
`ifdef TIMER_AUTO_RELOAD_EN
        cyc(0,0,0,0,1, t(0,1,0), 6'b000000, 0,0,1);
        cyc(0,0,0,0,0, t(0,1,0), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,1,0), 6'b000000, 0,0,0);
`else
        cyc(0,0,0,0,1, t(0,0,0), 6'b001111, 0,1,1);
        cyc(0,0,0,0,0, t(0,0,0), 6'b001111, 0,1,0);
        cyc(1,0,0,0,0, t(0,0,0), 6'b000000, 0,0,0);
`endif
        phase = "rst_a";
        do_reset();

        // ---------------- FIELDS=2, field editing ----------------
        phase = "edit";
        cyc(0,1,0,0,0, t(0,0,0),   6'b001100, 1,0,0);
        cyc(0,0,0,1,0, t(0,59,0),  6'b001100, 1,0,0);
        cyc(0,0,1,1,0, t(0,59,0),  6'b001100, 1,0,0);
        cyc(0,0,0,0,1, t(0,59,0),  6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,0),  6'b000011, 1,0,0);
        cyc(0,0,0,1,0, t(0,59,59), 6'b000011, 1,0,0);
        cyc(0,0,1,0,0, t(0,59,0),  6'b000011, 1,0,0);
        for (int s = 1; s <= 10; s++) begin
            cyc(0,0,1,0,0, t(0,59,s), 6'b000011, 1,0,0);
        end
        cyc(0,1,0,0,0, t(0,59,10), 6'b000000, 0,0,0);
        cyc(0,1,0,0,0, t(0,59,10), 6'b001100, 1,0,0);
        cyc(0,0,1,0,0, t(0,0,10),  6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,0,10),  6'b000011, 1,0,0);
        cyc(0,1,0,0,0, t(0,0,10),  6'b000000, 0,0,0);

        phase = "tick_pause";
        cyc(1,0,0,0,0, t(0,0,10), 6'b000000, 0,0,0);
        cyc(1,0,0,0,1, t(0,0,10), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,10), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,0,10), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,9),  6'b000000, 0,0,0);
        dir = 1;
        cyc(0,0,0,0,1, t(0,0,10), 6'b000000, 0,0,0);
        dir = 0;

        // ---------------- FIELDS=2, preset 00:03 (auto reload when enabled) ----------------
        phase = "preset3";
        cyc(0,1,0,0,0, t(0,0,10), 6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,0,10), 6'b000011, 1,0,0);
        for (int s = 9; s >= 3; s--) begin
            cyc(0,0,0,1,0, t(0,0,s), 6'b000011, 1,0,0);
        end
        cyc(0,1,0,0,0, t(0,0,3), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,0,3), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,2), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,1), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(0,0,0), 6'b000000, 0,0,0);
`ifdef TIMER_AUTO_RELOAD_EN
        cyc(0,0,0,0,1, t(0,0,3), 6'b000000, 0,0,1);
        cyc(0,0,0,0,1, t(0,0,2), 6'b000000, 0,0,0);
`else
        cyc(0,0,0,0,1, t(0,0,0), 6'b001111, 0,1,1);
        cyc(0,0,0,0,1, t(0,0,0), 6'b001111, 0,1,0);
`endif

        // ---------------- FIELDS=2, reset while running at 12:34 ----------------
        phase = "rst_b";
        do_reset();
        phase = "set_1234";
        cyc(0,1,0,0,0, t(0,0,0), 6'b001100, 1,0,0);
        for (int m = 1; m <= 12; m++) begin
            cyc(0,0,1,0,0, t(0,m,0), 6'b001100, 1,0,0);
        end
        cyc(0,1,0,0,0, t(0,12,0), 6'b000011, 1,0,0);
        for (int s = 1; s <= 34; s++) begin
            cyc(0,0,1,0,0, t(0,12,s), 6'b000011, 1,0,0);
        end
        cyc(0,1,0,0,0, t(0,12,34), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,12,34), 6'b000000, 0,0,0);
        phase = "rst_run";
        do_reset();
        cyc(0,0,0,0,1, t(0,0,0), 6'b000000, 0,0,0);

        // ---------------- FIELDS=3, up-count carry and expiry ----------------
        sel = 1;
        dir = 1;
        phase = "f3_set";
        cyc(0,1,0,0,0, t(0,0,0),   6'b110000, 1,0,0);
        cyc(0,1,0,0,0, t(0,0,0),   6'b001100, 1,0,0);
        cyc(0,0,0,1,0, t(0,59,0),  6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,0),  6'b000011, 1,0,0);
        cyc(0,0,0,1,0, t(0,59,59), 6'b000011, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,59), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,59,59), 6'b000000, 0,0,0);
        phase = "f3_carry";
        cyc(0,0,0,0,1, t(1,0,0),   6'b000000, 0,0,0);
        phase = "f3_max";
        cyc(0,1,0,0,0, t(1,0,0),   6'b110000, 1,0,0);
        cyc(0,0,0,1,0, t(0,0,0),   6'b110000, 1,0,0);
        cyc(0,0,0,1,0, t(23,0,0),  6'b110000, 1,0,0);
        cyc(0,1,0,0,0, t(23,0,0),  6'b001100, 1,0,0);
        cyc(0,0,0,1,0, t(23,59,0), 6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(23,59,0), 6'b000011, 1,0,0);
        cyc(0,0,0,1,0, t(23,59,59),6'b000011, 1,0,0);
        cyc(0,1,0,0,0, t(23,59,59),6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(23,59,59),6'b000000, 0,0,0);
        phase = "f3_expire";
        cyc(0,0,0,0,1, t(23,59,59),6'b111111, 0,1,1);
        cyc(0,0,0,0,1, t(23,59,59),6'b111111, 0,1,0);
        cyc(1,0,0,0,0, t(23,59,59),6'b000000, 0,0,0);
        phase = "f3_borrow";
        cyc(0,1,0,0,0, t(23,59,59),6'b110000, 1,0,0);
        cyc(0,0,1,0,0, t(0,59,59), 6'b110000, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,59), 6'b001100, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,59), 6'b000011, 1,0,0);
        cyc(0,1,0,0,0, t(0,59,59), 6'b000000, 0,0,0);
        cyc(1,0,0,0,0, t(0,59,59), 6'b000000, 0,0,0);
        cyc(0,0,0,0,1, t(1,0,0),   6'b000000, 0,0,0);
        dir = 0;
        cyc(0,0,0,0,1, t(0,59,59), 6'b000000, 0,0,0);

        phase = "end";
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/timer_core_p.md
Name: timer_core_p

Overview:
- Parametrised successor of the MM:SS countdown timer core.
- Holds SS / MM (optionally HH) as separate mod-N fields with carry/borrow.
- Supports count-down and count-up, per-field increment/decrement editing, pause, expiry alarm and per-digit blink mask.
- Sits between the debounce/prescaler front end and the 7-segment decode stage; it does no clock division itself.

Parameters:
- FIELDS, 2, number of time fields: 2 = MM:SS, 3 = HH:MM:SS.
- HR_MAX, 23, maximum hour value; used only when FIELDS=3.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle count enable from prescaler (1 Hz or accelerated)
- dir  in  1  0 = count down, 1 = count up; sampled every tick
- pause_p  in  1  one-cycle pulse; toggles run/pause, clears alarm
- mode_p  in  1  one-cycle pulse; steps through edit fields
- inc_p  in  1  one-cycle pulse; +1 to the field being edited
- dec_p  in  1  one-cycle pulse; -1 to the field being edited
- cnt_o  out  6*FIELDS  packed fields; [5:0]=SS, [11:6]=MM, [17:12]=HH
- blink_o  out  2*FIELDS  per-digit blink request; bit0 = SS ones
- edit_o  out  1  high in any EDIT state
- alarm_o  out  1  level, high in EXPIRED
- done_o  out  1  one-cycle pulse on the expiry transition

Behaviour:
- Reset (async): state PAUSED; cnt_o=0; preset=0; blink_o=0; edit_o=0; alarm_o=0; done_o=0.
- States: PAUSED, RUNNING, EDIT_HH (FIELDS=3 only), EDIT_MM, EDIT_SS, EXPIRED. All outputs are registered.
- Per-cycle priority: mode_p > pause_p > tick. A tick in the same cycle as mode_p or pause_p is dropped.
- PAUSED --pause_p--> RUNNING.
- RUNNING --pause_p--> PAUSED.
- PAUSED, RUNNING or EXPIRED --mode_p--> top edit field (EDIT_HH, or EDIT_MM when FIELDS=2).
- Edit order: EDIT_HH -> EDIT_MM -> EDIT_SS --mode_p--> PAUSED.
- Leaving EDIT_SS copies cnt into the preset register.
- RUNNING with tick, dir=0:
  - SS decrements; SS 0 -> 59 borrows from MM; MM 0 -> 59 borrows from HH.
  - A tick seen while all fields are 0 -> EXPIRED with done_o=1 for that cycle; cnt stays 0.
- RUNNING with tick, dir=1:
  - SS 59 -> 0 carries to MM; MM 59 -> 0 carries to HH (FIELDS=3).
  - A tick seen at max value -> EXPIRED with done_o; cnt holds max.
  - Max value: 59:59 when FIELDS=2; HR_MAX:59:59 when FIELDS=3.
- EXPIRED:
  - alarm_o=1; all blink_o bits 1.
  - pause_p -> PAUSED, alarm cleared, cnt unchanged.
- Edit states:
  - inc_p / dec_p wrap within the field only, with no carry into neighbours: SS/MM 0..59, HH 0..HR_MAX.
  - inc_p and dec_p in the same cycle: no change.
  - tick is ignored.
  - blink_o = ones on the two digits of the edited field.
- Any state other than EXPIRED and EDIT: blink_o=0.
- Fields are never written with values above their max. Arithmetic uses per-field compare/wrap, with no divide or modulo.
- Reset asserted mid-count or mid-edit: immediate return to reset values; preset is lost.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined, dir=0: the expiry tick loads cnt from preset, pulses done_o, and stays RUNNING; alarm_o stays 0.
  - If preset=0, behaviour is the same as when the macro is undefined.
- Defined, dir=1: no effect.
- Undefined: behaviour is as described under Behaviour.

Decomposition:
- Package timer_pkg holds:
  - state enum timer_state_t
  - localparam FW=6
  - SEC_MAX=59, MIN_MAX=59
  - helper function field_max(idx, HR_MAX)
- One sub-module, field_ctr: a single FW-bit mod-(MAX+1) up/down field.
  - Inputs: en, up, wrap-edit inc/dec.
  - Outputs: value, carry/borrow out.
  - timer_core_p instantiates FIELDS copies of it in a generate loop.

Test Plan:
- rst=1 mid-RUNNING at 12:34 -> cnt_o=0, state PAUSED, all outputs 0, asynchronously before the next clk edge.
- FIELDS=2, dir=0, preset 01:00, pause_p, 61 ticks:
  - 60th tick -> 00:00.
  - 61st tick -> done_o one cycle, alarm_o=1, blink_o=4'b1111.
  - pause_p -> alarm_o=0.
- FIELDS=3, dir=1, cnt 00:59:59, one tick -> 01:00:00.
  - At 23:59:59, a tick -> EXPIRED, cnt holds 23:59:59.
- Edit: mode_p -> EDIT_MM, blink_o=4'b1100; dec_p at MM=0 -> 59, SS unchanged; inc_p and dec_p together -> no change.
  - mode_p -> EDIT_SS, blink_o=4'b0011; inc_p at SS=59 -> 0, MM unchanged.
- Same cycle tick and pause_p while RUNNING at 00:10 -> PAUSED at 00:10, with no decrement.
- With TIMER_AUTO_RELOAD_EN, preset 00:03, dir=0: 4 ticks -> done_o pulse, cnt=00:03, still RUNNING, alarm_o=0.
